lcd_write_sequencer: RTL

Paces single LCD bus writes (command or data byte) against the 100 us tick produced by the team's LFSR timer. It drives the timer's enable/disable controls, consumes its one-cycle tick, and generates HD44780-style RS/RW/E/DB waveforms with setup, enable-pulse and execution delays counted in ticks. It sits between the display-content controller (byte source) and the LCD pins.

---
 rtl/lcd_write_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer
// Paces single HD44780-style LCD writes against an external 100 us tick.
// Each write runs a setup phase (E low), an enable pulse (E high) and an
// execution wait (E low). The wait is longer for clear/home commands.
// The sequencer also drives the tick timer's enable and phase-restart
// controls.
//
// Optional feature: define LCD_NIBBLE_MODE_EN for a 4-bit bus. Each byte
// is then sent as two setup/pulse pairs, high nibble first, on
// lcd_db[7:4]. lcd_db[3:0] stays 0 in this mode.
//
// Ports:
//   clock          system clock
//   rst            synchronous active-low reset
//   wr_valid       byte source has a write pending
//   wr_ready       idle and able to accept a write (combinational)
//   wr_rs          0 = command, 1 = data
//   wr_data        byte to write
//   tick           one-cycle 100 us pulse from the timer
//   timer_enable   timer EnableCount, high while a write is in progress
//   timer_disable  timer DisableCount, one-cycle phase restart on accept
//   lcd_rs         LCD register select
//   lcd_rw         LCD read/write, always 0
//   lcd_e          LCD enable strobe
//   lcd_db         LCD data bus
//   busy           high while a write is in progress
module lcd_write_sequencer #(
    parameter int unsigned SETUP_TICKS  = 1,
    parameter int unsigned E_HIGH_TICKS = 1,
    parameter int unsigned EXEC_TICKS   = 1,
    parameter int unsigned LONG_TICKS   = 17
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    input  logic       tick,
    output logic       timer_enable,
    output logic       timer_disable,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy
);

    localparam int unsigned CNT_W = 8;

    // A zero-tick phase is treated as a one-tick phase.
    localparam int unsigned SETUP_EFF = (SETUP_TICKS  == 0) ? 1 : SETUP_TICKS;
    localparam int unsigned E_EFF     = (E_HIGH_TICKS == 0) ? 1 : E_HIGH_TICKS;
    localparam int unsigned EXEC_EFF  = (EXEC_TICKS   == 0) ? 1 : EXEC_TICKS;
    localparam int unsigned LONG_EFF  = (LONG_TICKS   == 0) ? 1 : LONG_TICKS;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_EFF - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_EFF - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_EFF - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_limit;
    logic             r_long;
    logic             w_accept;
    logic             w_done;
    logic             w_lcd_e_d;
    logic             w_lcd_rs_d;
    logic [7:0]       w_lcd_db_d;
    logic             w_active_d;
`ifdef LCD_NIBBLE_MODE_EN
    logic             r_low_nib;
    logic [3:0]       r_low_data;
`endif

    assign wr_ready = rst & (r_state == S_IDLE);
    assign w_accept = wr_valid & wr_ready;
    assign lcd_rw   = 1'b0;

    // Last count value of the current phase.
    always_comb begin
        w_limit = '0;
        case (r_state)
            S_SETUP: w_limit = SETUP_LAST;
            S_PULSE: w_limit = E_LAST;
            S_EXEC:  w_limit = r_long ? LONG_LAST : EXEC_LAST;
            default: w_limit = '0;
        endcase
    end

    assign w_done = tick & (r_state != S_IDLE) & (r_cnt == w_limit);

    // State register.
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_SETUP;
            S_SETUP: if (w_done)   w_next_state = S_PULSE;
            S_PULSE: begin
                if (w_done) begin
`ifdef LCD_NIBBLE_MODE_EN
                    w_next_state = r_low_nib ? S_EXEC : S_SETUP;
`else
                    w_next_state = S_EXEC;
`endif
                end
            end
            S_EXEC:  if (w_done)   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        w_lcd_rs_d = lcd_rs;
        w_lcd_db_d = lcd_db;
        w_lcd_e_d  = (w_next_state == S_PULSE);
        w_active_d = (w_next_state != S_IDLE);
        if (w_accept) begin
            w_lcd_rs_d = wr_rs;
`ifdef LCD_NIBBLE_MODE_EN
            w_lcd_db_d = {wr_data[7:4], 4'h0};
`else
            w_lcd_db_d = wr_data;
`endif
        end
`ifdef LCD_NIBBLE_MODE_EN
        // First pulse done: present the low nibble for the second pair.
        if ((r_state == S_PULSE) && w_done && !r_low_nib) begin
            w_lcd_db_d = {r_low_data, 4'h0};
        end
`endif
    end

    // Tick counter, latched write attributes and registered outputs.
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_long        <= 1'b0;
            lcd_rs        <= 1'b0;
            lcd_db        <= 8'h00;
            lcd_e         <= 1'b0;
            busy          <= 1'b0;
            timer_enable  <= 1'b0;
            timer_disable <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
            r_low_nib     <= 1'b0;
            r_low_data    <= 4'h0;
`endif
        end else begin
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (tick && (r_state != S_IDLE)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_long <= ~wr_rs & ((wr_data == 8'h01) | (wr_data == 8'h02) |
                                    (wr_data == 8'h03));
            end
`ifdef LCD_NIBBLE_MODE_EN
            if (w_accept) begin
                r_low_nib  <= 1'b0;
                r_low_data <= wr_data[3:0];
            end else if ((r_state == S_PULSE) && w_done) begin
                r_low_nib  <= 1'b1;
            end
`endif
            lcd_rs        <= w_lcd_rs_d;
            lcd_db        <= w_lcd_db_d;
            lcd_e         <= w_lcd_e_d;
            busy          <= w_active_d;
            timer_enable  <= w_active_d;
            timer_disable <= w_accept;
        end
    end

endmodule
